// File: rtl/cntr_seq_ctrl.sv
// cntr_seq_ctrl
//   Command-driven sequencer for an M-bit reversible loadable counter.
//   It accepts one command at a time (direction, start value, step count and
//   stop-on-TC flag), loads the counter, and then issues prescaled
//   single-cycle ce pulses. It stops when the step budget is spent, when TC
//   is reached (if requested) or when the command is aborted.
//
// Ports
//   clk, clr        : clock (rising edge) and synchronous active-high reset
//   cmd_vld/cmd_rdy : command handshake; accept = cmd_vld & cmd_rdy
//   cmd_up          : direction (1 = up, 0 = down)
//   cmd_start       : value loaded into the counter
//   cmd_len         : number of ce pulses requested (0 allowed)
//   cmd_stop_tc     : end early when the counter reports TC
//   abort           : terminate the current command
//   cnt_L/cnt_di    : counter load strobe and load data
//   cnt_up/cnt_ce   : counter direction and count enable
//   cnt_q/cnt_tc    : counter value and terminal-count monitor inputs
//   busy, done      : activity flag and single-cycle completion pulse
//   steps_done      : ce pulses issued for the last or current command
//   tc_hit, aborted : how the last command ended
//   final_q         : cnt_q sampled in the DONE cycle
module cntr_seq_ctrl #(
  parameter int M   = 4,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         cmd_vld,
  output logic         cmd_rdy,
  input  logic         cmd_up,
  input  logic [M-1:0] cmd_start,
  input  logic [M-1:0] cmd_len,
  input  logic         cmd_stop_tc,
  input  logic         abort,
  output logic         cnt_L,
  output logic [M-1:0] cnt_di,
  output logic         cnt_up,
  output logic         cnt_ce,
  input  logic [M-1:0] cnt_q,
  input  logic         cnt_tc,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] steps_done,
  output logic         tc_hit,
  output logic         aborted,
  output logic [M-1:0] final_q
);

  // The prescaler needs at least one bit even when DIV = 1.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TICK_VAL = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic           r_cnt_up;
  logic [M-1:0]   r_start;
  logic [M-1:0]   r_len;
  logic           r_stop_tc;
  logic [PW-1:0]  r_presc;
  logic [M-1:0]   r_steps;
  logic           r_tc_hit;
  logic           r_aborted;
  logic [M-1:0]   r_final_q;

  logic           w_accept;
  logic           w_tick;
  logic           w_tc_stop;
  logic           w_last;
  logic           w_ce;
  logic [M-1:0]   w_steps_inc;

  assign w_accept    = cmd_vld && (r_state == S_IDLE);
  assign w_tick      = (r_presc == TICK_VAL);
  // TC is examined before a ce would be issued on the same tick.
  assign w_tc_stop   = w_tick && r_stop_tc && cnt_tc;
  assign w_steps_inc = r_steps + M'(1);
  assign w_last      = (w_steps_inc == r_len);

  // Next-state and ce decode
  always_comb begin
    w_next = r_state;
    w_ce   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort || (r_len == '0)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next = S_DONE;
        end else if (w_tc_stop) begin
          w_next = S_DONE;
        end else if (w_tick) begin
          w_ce = 1'b1;
          if (w_last) begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, captured command and status registers
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_cnt_up  <= 1'b1;
      r_start   <= '0;
      r_len     <= '0;
      r_stop_tc <= 1'b0;
      r_presc   <= '0;
      r_steps   <= '0;
      r_tc_hit  <= 1'b0;
      r_aborted <= 1'b0;
      r_final_q <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt_up  <= cmd_up;
            r_start   <= cmd_start;
            r_len     <= cmd_len;
            r_stop_tc <= cmd_stop_tc;
            r_steps   <= '0;
            r_tc_hit  <= 1'b0;
            r_aborted <= 1'b0;
          end
        end
        S_LOAD: begin
          r_presc <= '0;
          if (abort) begin
            r_aborted <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_aborted <= 1'b1;
          end else if (w_tc_stop) begin
            r_tc_hit <= 1'b1;
          end else begin
            r_presc <= w_tick ? '0 : (r_presc + PW'(1));
            if (w_tick) begin
              r_steps <= w_steps_inc;
            end
          end
        end
        S_DONE: begin
          r_final_q <= cnt_q;
        end
        default: begin
          r_presc <= '0;
        end
      endcase
    end
  end

  // Output decode
  assign cmd_rdy    = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign cnt_L      = (r_state == S_LOAD);
  // Load data is driven only while loading so the bus idles at zero.
  assign cnt_di     = (r_state == S_LOAD) ? r_start : '0;
  assign cnt_up     = r_cnt_up;
  assign cnt_ce     = w_ce;
  assign steps_done = r_steps;
  assign tc_hit     = r_tc_hit;
  assign aborted    = r_aborted;
  assign final_q    = r_final_q;

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
module tb_cntr_seq_ctrl;

  localparam int M  = 4;
  localparam int NI = 2;

  logic         clk = 1'b0;
  logic         clr;
  logic         cmd_vld;
  logic         cmd_up;
  logic [M-1:0] cmd_start;
  logic [M-1:0] cmd_len;
  logic         cmd_stop_tc;
  logic         abort;

  logic         rdy  [NI];
  logic         cL   [NI];
  logic [M-1:0] cdi  [NI];
  logic         cup  [NI];
  logic         cce  [NI];
  logic [M-1:0] q    [NI];
  logic         tc   [NI];
  logic         busy [NI];
  logic         dn   [NI];
  logic [M-1:0] steps[NI];
  logic         tch  [NI];
  logic         abd  [NI];
  logic [M-1:0] fq   [NI];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int div_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Instance 0 runs with DIV = 1, instance 1 with DIV = 3; each drives its own counter.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    cntr_seq_ctrl #(.M(M), .DIV((g == 0) ? 1 : 3)) u_dut (
      .clk(clk), .clr(clr),
      .cmd_vld(cmd_vld), .cmd_rdy(rdy[g]), .cmd_up(cmd_up),
      .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_stop_tc(cmd_stop_tc),
      .abort(abort),
      .cnt_L(cL[g]), .cnt_di(cdi[g]), .cnt_up(cup[g]), .cnt_ce(cce[g]),
      .cnt_q(q[g]), .cnt_tc(tc[g]),
      .busy(busy[g]), .done(dn[g]), .steps_done(steps[g]),
      .tc_hit(tch[g]), .aborted(abd[g]), .final_q(fq[g])
    );
    assign tc[g] = cup[g] ? (q[g] == '1) : (q[g] == '0);
  end

  // Reversible loadable counter driven by each controller
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (clr)         q[i] <= '0;
      else if (cL[i])  q[i] <= cdi[i];
      else if (cce[i]) q[i] <= cup[i] ? q[i] + M'(1) : q[i] - M'(1);
    end
  end

  // Behavioural model: each command is planned at accept time as a timeline
  // relative to its LOAD cycle (t = 0): RUN occupies t = 1..R, DONE is t = R+1,
  // ce falls on t = k*DIV for k = 1..s. Abort truncates the plan.
  bit           m_act [NI];
  int           m_t   [NI];
  int           m_R   [NI];
  int           m_s   [NI];
  bit           m_tcr [NI];
  logic [M-1:0] m_start[NI];
  bit           m_up  [NI];
  bit           m_ab  [NI];
  bit           m_tc  [NI];
  int           m_sv  [NI];
  logic [M-1:0] m_fq  [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      automatic int d = div_of(i);
      automatic int t, r, s, ln;
      automatic bit tcr;
      automatic logic [M-1:0] v;
      if (clr) begin
        m_act[i] <= 1'b0; m_t[i] <= 0; m_R[i] <= 0; m_s[i] <= 0; m_tcr[i] <= 1'b0;
        m_start[i] <= '0; m_up[i] <= 1'b1; m_ab[i] <= 1'b0; m_tc[i] <= 1'b0;
        m_sv[i] <= 0; m_fq[i] <= '0;
      end else if (!m_act[i]) begin
        if (cmd_vld) begin
          ln  = int'(cmd_len);
          s   = ln;
          r   = ln * d;
          tcr = 1'b0;
          for (int k = 0; k < ln; k++) begin
            v = cmd_up ? cmd_start + M'(k) : cmd_start - M'(k);
            if (cmd_stop_tc && (cmd_up ? (v == '1) : (v == '0))) begin
              s = k; r = (k + 1) * d; tcr = 1'b1;
              break;
            end
          end
          m_act[i] <= 1'b1; m_t[i] <= 0; m_R[i] <= r; m_s[i] <= s; m_tcr[i] <= tcr;
          m_start[i] <= cmd_start; m_up[i] <= cmd_up;
          m_ab[i] <= 1'b0; m_tc[i] <= 1'b0; m_sv[i] <= 0;
        end
      end else begin
        t = m_t[i]; r = m_R[i]; s = m_s[i];
        if (t <= r && abort) begin
          m_R[i] <= t; m_s[i] <= (t == 0) ? 0 : (t - 1) / d;
          m_ab[i] <= 1'b1; m_tcr[i] <= 1'b0;
        end else if (t == r && m_tcr[i]) begin
          m_tc[i] <= 1'b1;
        end
        if (t == r + 1) begin
          m_act[i] <= 1'b0;
          m_sv[i]  <= s;
          m_fq[i]  <= m_up[i] ? m_start[i] + M'(s) : m_start[i] - M'(s);
        end
        m_t[i] <= t + 1;
      end
    end
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        automatic int d = div_of(i);
        automatic int t = m_t[i];
        automatic bit a = m_act[i];
        automatic int e_steps;
        automatic bit e_ce;
        e_ce = a && t >= 1 && t <= m_R[i] && (t % d == 0) && (t / d <= m_s[i]) && !abort;
        if (!a)          e_steps = m_sv[i];
        else if (t == 0) e_steps = 0;
        else             e_steps = ((t - 1) / d < m_s[i]) ? (t - 1) / d : m_s[i];
        chk("cmd_rdy", i, int'(rdy[i]), int'(!a));
        chk("busy", i, int'(busy[i]), int'(a));
        chk("cnt_L", i, int'(cL[i]), int'(a && t == 0));
        chk("cnt_di", i, int'(cdi[i]), (a && t == 0) ? int'(m_start[i]) : 0);
        chk("cnt_up", i, int'(cup[i]), int'(m_up[i]));
        chk("cnt_ce", i, int'(cce[i]), int'(e_ce));
        chk("done", i, int'(dn[i]), int'(a && t == m_R[i] + 1));
        chk("steps_done", i, int'(steps[i]), e_steps);
        chk("tc_hit", i, int'(tch[i]), int'(m_tc[i]));
        chk("aborted", i, int'(abd[i]), int'(m_ab[i]));
        chk("final_q", i, int'(fq[i]), int'(m_fq[i]));
      end
    end
  end

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(rdy[0] && rdy[1])) begin
      n_chk++; n_err++;
      $display("FAIL wait_idle: timed out after %0d cycles, rdy0=%0d rdy1=%0d", n, rdy[0], rdy[1]);
    end
  endtask

  // Present a command for one edge; afterwards both instances sit in LOAD.
  task automatic send(input bit up, input int st, input int ln, input bit stp);
    wait_idle(300);
    cmd_up = up; cmd_start = M'(st); cmd_len = M'(ln); cmd_stop_tc = stp;
    cmd_vld = 1'b1;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  initial begin
    logic [6:0] cev, dnv;
    clr = 1'b1; cmd_vld = 1'b0; cmd_up = 1'b0; cmd_start = '0; cmd_len = '0;
    cmd_stop_tc = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    chk_en = 1'b1;
    chk("rst_rdy", 0, int'(rdy[0]), 1);
    chk("rst_busy", 0, int'(busy[0]), 0);
    chk("rst_cnt_up", 0, int'(cup[0]), 1);
    chk("rst_final_q", 0, int'(fq[0]), 0);

    // Up count from 3 for 5 steps
    send(1'b1, 3, 5, 1'b0);
    chk("t1_load", 0, int'(cL[0]), 1);
    chk("t1_di", 0, int'(cdi[0]), 3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t1_ce", 0, int'(cce[0]), 1);
    end
    @(posedge clk); #1;
    chk("t1_done", 0, int'(dn[0]), 1);
    wait_idle(300);
    chk("t1_final_q", 0, int'(fq[0]), 8);
    chk("t1_model_fq", 0, int'(m_fq[0]), 8);
    chk("t1_steps", 0, int'(steps[0]), 5);
    chk("t1_tc_hit", 0, int'(tch[0]), 0);
    chk("t1_final_q", 1, int'(fq[1]), 8);

    // Down from 2 with stop-on-TC
    send(1'b0, 2, 6, 1'b1);
    wait_idle(300);
    chk("t2_tc_hit", 0, int'(tch[0]), 1);
    chk("t2_steps", 0, int'(steps[0]), 2);
    chk("t2_model_steps", 0, m_sv[0], 2);
    chk("t2_final_q", 0, int'(fq[0]), 0);
    chk("t2_tc_hit", 1, int'(tch[1]), 1);

    // Wrap-around up from 14
    send(1'b1, 14, 4, 1'b0);
    wait_idle(300);
    chk("t3_final_q", 0, int'(fq[0]), 2);
    chk("t3_tc_hit", 0, int'(tch[0]), 0);

    // Zero-length command: LOAD then DONE
    send(1'b1, 7, 0, 1'b0);
    chk("t3z_load", 0, int'(cL[0]), 1);
    @(posedge clk); #1;
    chk("t3z_done", 0, int'(dn[0]), 1);
    chk("t3z_steps", 0, int'(steps[0]), 0);
    wait_idle(300);
    chk("t3z_final_q", 0, int'(fq[0]), 7);

    // DIV = 3 instance: ce only in RUN cycles 3 and 6, DONE in cycle 7
    send(1'b1, 0, 2, 1'b0);
    cev = '0; dnv = '0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      cev[c] = cce[1];
      dnv[c] = dn[1];
    end
    chk("t4_ce_pattern", 1, int'(cev), int'(7'b0100100));
    chk("t4_done_pattern", 1, int'(dnv), int'(7'b1000000));
    wait_idle(300);
    chk("t4_final_q", 1, int'(fq[1]), 2);

    // Abort in the third RUN cycle while a new command is held valid
    send(1'b1, 0, 10, 1'b0);
    cmd_up = 1'b0; cmd_start = 4'd5; cmd_len = 4'd1; cmd_stop_tc = 1'b0;
    cmd_vld = 1'b1;
    chk("t5_rdy_load", 0, int'(rdy[0]), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_rdy_run", 0, int'(rdy[0]), 0);
    @(posedge clk); #1;
    abort = 1'b1;
    #1;
    chk("t5_ce_abort", 0, int'(cce[0]), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_done", 0, int'(dn[0]), 1);
    chk("t5_rdy_done", 0, int'(rdy[0]), 0);
    chk("t5_aborted", 0, int'(abd[0]), 1);
    @(posedge clk); #1;
    chk("t5_rdy_idle", 0, int'(rdy[0]), 1);
    chk("t5_steps", 0, int'(steps[0]), 2);
    chk("t5_aborted_hold", 0, int'(abd[0]), 1);
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    chk("t5_accept_load", 0, int'(cL[0]), 1);
    chk("t5_accept_di", 0, int'(cdi[0]), 5);
    chk("t5_aborted_clr", 0, int'(abd[0]), 0);
    wait_idle(300);

    // Synchronous clear mid-RUN
    send(1'b0, 0, 10, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("t6_busy", 0, int'(busy[0]), 0);
    chk("t6_rdy", 0, int'(rdy[0]), 1);
    chk("t6_ce", 0, int'(cce[0]), 0);
    chk("t6_cnt_up", 0, int'(cup[0]), 1);
    chk("t6_steps", 0, int'(steps[0]), 0);
    chk("t6_aborted", 0, int'(abd[0]), 0);

    // Randomized traffic checked cycle-by-cycle against the model
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      cmd_vld     = ($urandom % 3) == 0;
      cmd_up      = $urandom % 2;
      cmd_start   = M'($urandom);
      cmd_len     = M'($urandom);
      cmd_stop_tc = $urandom % 2;
      abort       = ($urandom % 30) == 0;
      clr         = ($urandom % 700) == 0;
    end
    @(posedge clk); #1;
    cmd_vld = 1'b0; abort = 1'b0; clr = 1'b0;
    wait_idle(300);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
